// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, message-locked arbiter that shares one UART byte
//               transmitter among NUM_REQ sources, with an idle gap between
//               messages. Optional owner-stall abort: UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   last,
    input  logic [8*NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (IDX_W < $clog2(NUM_REQ) || NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_owner;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] r_grant;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               w_owner_req;
    logic               w_owner_last;
    logic [7:0]         w_owner_byte;
    logic               w_take;
    logic               w_done;
    logic               w_timeout;

    always_comb begin : owner_mux
        w_owner_req  = 1'b0;
        w_owner_last = 1'b0;
        w_owner_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_owner_req  = req[i];
                w_owner_last = last[i];
                w_owner_byte = din[8*i +: 8];
            end
        end
    end

    // Scan from farthest to nearest so the nearest index after last_owner wins.
    always_comb begin : rr_pick
        int idx;
        w_pick = r_last_owner;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_last_owner) + k) % NUM_REQ;
            if (req[idx]) begin
                w_pick = IDX_W'(idx);
            end
        end
    end

    assign w_take = !rst && (r_state == S_SEND) && w_owner_req && (!r_tx_valid || tx_ready);
    assign w_done = (w_take && w_owner_last) || w_timeout;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin : stall_counter
        if (rst || r_state != S_SEND || w_take || w_timeout) begin
            r_stall_cnt <= '0;
        end else if (!w_owner_req) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle itself.
    assign w_timeout = !rst && (r_state == S_SEND) && !w_owner_req
                       && (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_state_nxt = S_SEND;
            S_SEND:  if (w_done) w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_gap_cnt    <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
        end else begin
            if (w_take) begin
                r_tx_data  <= w_owner_byte;
                r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner <= w_pick;
                        r_grant <= NUM_REQ'(1) << w_pick;
                    end
                end
                S_SEND: begin
                    if (w_done) begin
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                        r_gap_cnt    <= GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack      = r_grant & {NUM_REQ{w_take}};
    assign grant    = r_grant;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = (r_state != S_IDLE) || r_tx_valid;
    assign timeout  = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Testbench for uart_tx_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a message-level model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, last, ack, grant;
    logic [31:0] din;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(N), .IDX_W(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .din(din),
        .ack(ack), .grant(grant), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .timeout(timeout)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 = none), remaining gap cycles, output byte.
    int         m_owner, m_last, m_gap;
    logic       m_valid;
    logic [7:0] m_data;

    // Values seen during the most recent step (sampled before the edge).
    logic [3:0] s_ack, s_grant;
    logic       s_txv;
    logic [7:0] s_txd;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] din;
        logic        rdy;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic        valid;
        logic [7:0]  data;
        logic        busy;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rbits(input int pct);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < pct);
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gap   = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        req = 4'($urandom); last = 4'($urandom); din = $urandom; tx_ready = 1'($urandom);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            check("rst_ack", 32'(ack), 0);
            check("rst_grant", 32'(grant), 0);
            check("rst_tx_valid", 32'(tx_valid), 0);
            check("rst_tx_data", 32'(tx_data), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_timeout", 32'(timeout), 0);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0;
        model_reset();
    endtask

    // One model-checked cycle. Called at a negedge; returns at the next negedge.
    task automatic step(input logic [3:0] rq, input logic [3:0] lst,
                        input logic [31:0] d, input logic rdy);
        logic [3:0] e_grant, e_ack;
        logic       take;
        req = rq; last = lst; din = d; tx_ready = rdy;
        #1;
        e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        take = 1'b0;
        if (m_owner >= 0) take = rq[m_owner] && (!m_valid || rdy);
        e_ack = take ? e_grant : 4'b0;
        check("ack", 32'(ack), 32'(e_ack));
        check("grant", 32'(grant), 32'(e_grant));
        check("tx_valid", 32'(tx_valid), 32'(m_valid));
        check("tx_data", 32'(tx_data), 32'(m_data));
        check("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0) || m_valid));
        check("timeout", 32'(timeout), 0);
        s_ack = ack; s_grant = grant; s_txv = tx_valid; s_txd = tx_data;
        @(posedge clk);
        if (take) begin
            m_data  = d[8*m_owner +: 8];
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (m_gap > 0) begin
                m_gap--;
            end else if (rq != 4'b0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && rq[(m_last + k) % N]) m_owner = (m_last + k) % N;
                end
            end
        end else if (take && lst[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_gap   = GAP;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt[4];
        int         order[$];
        logic [3:0] prev_grant;
        logic [7:0] bytes[$];
        logic [7:0] seen[$];
        int         sent, n, ack2_seen;
        logic       r;

        tbl[0] = '{4'b0001, 4'b0000, 32'hAABBCC48, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{4'b0001, 4'b0000, 32'hAABBCC48, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{4'b0001, 4'b0000, 32'hAABBCC69, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h48, 1'b1};
        tbl[3] = '{4'b0001, 4'b0001, 32'hAABBCC0A, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h69, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h0A, 1'b1};
        tbl[5] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h0A, 1'b1};

        rst = 1'b1; req = 4'b0; last = 4'b0; din = 32'b0; tx_ready = 1'b1;
        @(negedge clk);
        do_reset(10);

        // "Hi\n" from requester 0 with the transmitter always ready.
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; last = tbl[i].last; din = tbl[i].din; tx_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].data));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            @(posedge clk); @(negedge clk);
        end
        for (int i = 0; i < GAP - 2; i++) begin
            req = 4'b0; #1;
            check("gap_busy", 32'(busy), 1);
            check("gap_grant", 32'(grant), 0);
            @(posedge clk); @(negedge clk);
        end
        #1;
        check("gap_end_busy", 32'(busy), 0);
        @(negedge clk);

        // Round robin with all four sources requesting two-byte messages.
        do_reset(2);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        prev_grant = 4'b0;
        n = 0;
        while (order.size() < 5 && n < 400) begin
            step(4'b1111, {1'(cnt[3] % 2), 1'(cnt[2] % 2), 1'(cnt[1] % 2), 1'(cnt[0] % 2)},
                 $urandom, 1'b1);
            for (int i = 0; i < 4; i++) if (s_ack[i]) cnt[i]++;
            if (s_grant != 4'b0 && s_grant != prev_grant) begin
                for (int i = 0; i < 4; i++) if (s_grant[i]) order.push_back(i);
            end
            prev_grant = s_grant;
            n++;
        end
        check("rr_grant_count", 32'(order.size()), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));

        // Backpressure: 6-byte message from source 1, tx_ready low for 5 cycles.
        do_reset(2);
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        seen.delete();
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            r = !(c >= 4 && c < 9);
            if (sent < 6)
                step(4'b0010, {2'b00, 1'(sent == 5), 1'b0}, {16'hDEAD, bytes[sent], 8'hBE}, r);
            else
                step(4'b0000, 4'b0000, 32'h0, r);
            if (s_ack[1]) sent++;
            if (s_txv && r) seen.push_back(s_txd);
        end
        check("bp_byte_count", 32'(seen.size()), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            check($sformatf("bp_byte%0d", i), 32'(seen[i]), 32'(bytes[i]));

        // Owner stall: source 0 goes quiet for 20 cycles while source 2 waits.
        do_reset(2);
        sent = 0;
        ack2_seen = 0;
        for (int c = 0; c < 10 && sent == 0; c++) begin
            step(4'b0001, 4'b0000, 32'h000000A0, 1'b1);
            if (s_ack[0]) sent++;
        end
        check("stall_first_byte", 32'(sent), 1);
        for (int c = 0; c < 20; c++) begin
            step(4'b0100, 4'b0100, $urandom, 1'($urandom));
            if (s_ack[2]) ack2_seen++;
            if (c == 19) check("stall_grant_held", 32'(s_grant), 32'h1);
        end
        for (int c = 0; c < 10 && sent == 1; c++) begin
            step(4'b0101, 4'b0001, 32'h00C300A1, 1'b1);
            if (s_ack[0]) sent++;
            if (s_ack[2]) ack2_seen++;
        end
        check("stall_msg_done", 32'(sent), 2);
        check("stall_ack2_never", 32'(ack2_seen), 0);
        for (int c = 0; c < GAP + 6; c++) step(4'b0100, 4'b0100, $urandom, 1'b1);

        // Randomized traffic with occasional reset.
        do_reset(2);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(2);
            end else begin
                step(rbits(60), rbits(30), $urandom, $urandom_range(0, 99) < 70);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
